// File: rtl/alu_c_bus_writeback_pkg.sv
// alu_c_bus_writeback_pkg: shared constants and state encoding for the C-bus write-back path.
package alu_c_bus_writeback_pkg;
    localparam int DATA_W    = 18;
    localparam int DEST_IDR  = 0;
    localparam int DEST_MDR  = 1;
    localparam int DEST_RCOL = 2;
    localparam int DEST_RROW = 3;
    typedef enum logic [1:0] {IDLE, WRITE, MEM_WAIT} wb_state_t;
endpackage

// File: rtl/alu_c_bus_writeback_if.sv
// alu_c_bus_writeback_if: ALU result handshake, C-bus strobes and memory write handshake.
interface alu_c_bus_writeback_if import alu_c_bus_writeback_pkg::*; #(
    parameter int DW = DATA_W,
    parameter int ND = 8
);
    logic          wb_valid, wb_ready, wb_store;
    logic [DW-1:0] wb_data, c_bus;
    logic [ND-1:0] wb_dest, write_en;
    logic          mem_wr_req, mem_ack, busy, err, err_clr;
    modport master (
        output wb_valid, wb_data, wb_dest, wb_store, mem_ack, err_clr,
        input  wb_ready, c_bus, write_en, mem_wr_req, busy, err
    );
    modport slave (
        input  wb_valid, wb_data, wb_dest, wb_store, mem_ack, err_clr,
        output wb_ready, c_bus, write_en, mem_wr_req, busy, err
    );
endinterface

// File: rtl/alu_c_bus_writeback_wb_timeout_cnt.sv
// wb_timeout_cnt: loadable/clearable down-counter; expired_o is high once the count sits at zero.
module wb_timeout_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign expired_o = cnt_q == '0;
endmodule

// File: rtl/alu_c_bus_writeback.sv
// alu_c_bus_writeback: drives accepted ALU results onto the C bus, pulses destination strobes
// and, for MDR stores, runs a memory write handshake bounded by a timeout.
module alu_c_bus_writeback import alu_c_bus_writeback_pkg::*; #(
    parameter int DATA_W   = 18,
    parameter int NUM_DEST = 8,
    parameter int MDR_BIT  = DEST_MDR,
    parameter int TIMEOUT  = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    alu_c_bus_writeback_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Loaded with TIMEOUT-1 so the counter hits zero on the TIMEOUT-th MEM_WAIT cycle.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    wb_state_t             state_q, state_d;
    logic [DATA_W-1:0]     c_bus_q, c_bus_d;
    logic [NUM_DEST-1:0]   dest_q, dest_d;
    logic                  store_q, store_d, err_q, err_d;
    logic                  cnt_load, cnt_en, expired, timeout;

    wb_timeout_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q == IDLE),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (LOAD_VAL),
        .expired_o  (expired)
    );

    always_comb begin
        state_d  = state_q;
        c_bus_d  = c_bus_q;
        dest_d   = dest_q;
        store_d  = store_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: if (bus.wb_valid) begin
                c_bus_d = bus.wb_data;
                dest_d  = bus.wb_dest;
                store_d = bus.wb_store;
                state_d = WRITE;
            end
            WRITE: begin
                cnt_load = store_q && dest_q[MDR_BIT];
                state_d  = cnt_load ? MEM_WAIT : IDLE;
            end
            MEM_WAIT: begin
                cnt_en  = 1'b1;
                timeout = !bus.mem_ack && expired;
                state_d = (bus.mem_ack || expired) ? IDLE : MEM_WAIT;
            end
            default: state_d = IDLE;
        endcase
        err_d = timeout || (err_q && !bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            c_bus_q <= '0;
            dest_q  <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_bus_q <= c_bus_d;
            dest_q  <= dest_d;
            store_q <= store_d;
            err_q   <= err_d;
        end

    assign bus.wb_ready   = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.write_en   = state_q == WRITE ? dest_q : '0;
    assign bus.mem_wr_req = state_q == MEM_WAIT;
    assign bus.c_bus      = c_bus_q;
    assign bus.err        = err_q;
endmodule
